pci_cfg_space: RTL and testbench

- PCI Type-0 configuration space register file, directly downstream of the constant ID/class-code block.
- Consumes the device/vendor ID word and the class-code/revision word from that block.
- Serves dword config reads and writes from the PCI target front-end.
- Holds the command, status, BAR0, latency-timer and interrupt-line registers.
- Produces the decode-enable bits and a registered BAR0 address-hit flag for the target datapath.

---
 rtl/pci_cfg_space_if.sv | 21 ++
 rtl/pci_cfg_space.sv | 143 ++++++++++++++
 tb/tb_pci_cfg_space.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pci_cfg_space_if.sv
// Config access bus between the PCI target front-end (master) and the
// Type-0 configuration register file (slave).
interface pci_cfg_space_if;
    logic        CFG_REQ;
    logic        CFG_WE;
    logic [5:0]  CFG_ADDR;
    logic [3:0]  CFG_BE;
    logic [31:0] CFG_WDATA;
    logic [31:0] CFG_RDATA;
    logic        CFG_ACK;

    modport master (
        output CFG_REQ, CFG_WE, CFG_ADDR, CFG_BE, CFG_WDATA,
        input  CFG_RDATA, CFG_ACK
    );

    modport slave (
        input  CFG_REQ, CFG_WE, CFG_ADDR, CFG_BE, CFG_WDATA,
        output CFG_RDATA, CFG_ACK
    );
endinterface

// File: rtl/pci_cfg_space.sv
// PCI Type-0 configuration space register file.
// Holds command/status, BAR0, latency timer and interrupt line; serves
// dword config accesses with a one-cycle ACK and produces the decode
// enables plus a registered BAR0 address-hit flag.
// Optional feature macro: CFG_SUBSYS_EN (index 0x0B reads SUBSYS_ID).
module pci_cfg_space #(
    parameter logic [31:0] BAR0_MASK = 32'hFFFF_FFF0,
    parameter logic        BAR0_IO   = 1'b1,
    parameter logic [7:0]  INT_PIN   = 8'h01,
    parameter logic [31:0] SUBSYS_ID = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           CFG_VENDOR,
    input  logic [31:0]           CFG_CC_REVISION,
    pci_cfg_space_if.slave        cfg,
    input  logic                  STAT_STA,
    output logic                  IO_EN,
    output logic                  MEM_EN,
    output logic                  BM_EN,
    output logic [31:0]           BAR0,
    input  logic [31:0]           ADDR_IN,
    input  logic                  ADDR_VALID,
    output logic                  BAR0_HIT
);
    // Command bits that exist: I/O, memory, bus master, parity, SERR.
    localparam logic [15:0] CMD_WMASK = 16'h0147;
    localparam logic [31:0] BAR0_TYPE = BAR0_IO ? 32'h0000_0001 : 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, ACK, DROP} state_t;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cfg_req_t;

    state_t      state;
    cfg_req_t    req_q;
    logic [15:0] cmd_q;
    logic        sta_q;
    logic [7:0]  lat_q;
    logic [7:0]  intl_q;
    logic [31:0] bar0_q;
    logic [31:0] rd_mux;
    logic [31:0] wdata_bar;
    logic        wr_now;

`ifndef CFG_SUBSYS_EN
    logic unused_subsys;
    assign unused_subsys = ^SUBSYS_ID;
`endif

    assign IO_EN     = cmd_q[0];
    assign MEM_EN    = cmd_q[1];
    assign BM_EN     = cmd_q[2];
    assign BAR0      = bar0_q | BAR0_TYPE;
    assign wdata_bar = req_q.wdata & BAR0_MASK;
    // The latched write commits on the edge that ends the ACK cycle, so a
    // reset landing during ACK discards it.
    assign wr_now    = (state == ACK) && req_q.we;

    // Read mux, evaluated against the live address while IDLE.
    always_comb begin
        rd_mux = 32'h0;
        case (cfg.CFG_ADDR)
            6'h00: rd_mux = CFG_VENDOR;
            6'h01: rd_mux = {4'h0, sta_q, 1'b0, 1'b1, 9'h0, cmd_q};
            6'h02: rd_mux = CFG_CC_REVISION;
            6'h03: rd_mux = {16'h0, lat_q, 8'h0};
            6'h04: rd_mux = BAR0;
            6'h0F: rd_mux = {16'h0, INT_PIN, intl_q};
`ifdef CFG_SUBSYS_EN
            6'h0B: rd_mux = SUBSYS_ID;
`endif
            default: rd_mux = 32'h0;
        endcase
    end

    // Access FSM: latch request, pulse ACK with read data, wait for REQ drop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            req_q         <= '0;
            cfg.CFG_ACK   <= 1'b0;
            cfg.CFG_RDATA <= 32'h0;
        end else begin
            cfg.CFG_ACK   <= 1'b0;
            cfg.CFG_RDATA <= 32'h0;
            case (state)
                IDLE: if (cfg.CFG_REQ) begin
                    req_q         <= '{we: cfg.CFG_WE, addr: cfg.CFG_ADDR,
                                       be: cfg.CFG_BE, wdata: cfg.CFG_WDATA};
                    cfg.CFG_ACK   <= 1'b1;
                    cfg.CFG_RDATA <= rd_mux;
                    state         <= ACK;
                end
                ACK:  state <= DROP;
                DROP: if (!cfg.CFG_REQ) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register writes under byte enables; status bit27 is set-wins RW1C.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q  <= 16'h0;
            sta_q  <= 1'b0;
            lat_q  <= 8'h0;
            intl_q <= 8'h0;
            bar0_q <= 32'h0;
        end else begin
            if (wr_now) begin
                case (req_q.addr)
                    6'h01: for (int b = 0; b < 2; b++)
                        if (req_q.be[b])
                            cmd_q[8*b +: 8] <= req_q.wdata[8*b +: 8] & CMD_WMASK[8*b +: 8];
                    6'h03: if (req_q.be[1]) lat_q <= req_q.wdata[15:8];
                    6'h04: for (int b = 0; b < 4; b++)
                        if (req_q.be[b])
                            bar0_q[8*b +: 8] <= wdata_bar[8*b +: 8];
                    6'h0F: if (req_q.be[0]) intl_q <= req_q.wdata[7:0];
                    default: ;
                endcase
            end
            if (STAT_STA)
                sta_q <= 1'b1;
            else if (wr_now && req_q.addr == 6'h01 && req_q.be[3] && req_q.wdata[27])
                sta_q <= 1'b0;
        end
    end

    // Registered BAR0 decode, gated by the matching space enable.
    always_ff @(posedge CLK) begin
        if (RST)
            BAR0_HIT <= 1'b0;
        else
            BAR0_HIT <= ADDR_VALID && ((ADDR_IN & BAR0_MASK) == (BAR0 & BAR0_MASK))
                        && (BAR0_IO ? IO_EN : MEM_EN);
    end
endmodule

// File: tb/tb_pci_cfg_space.sv
// Bench for pci_cfg_space: directed vector table, hand sequences for
// status RW1C, decode and reset-mid-access, then random traffic against
// a register-map model.
module tb_pci_cfg_space;
    localparam logic [31:0] MASK   = 32'hFFFF_FFF0;
    localparam logic [31:0] SUBSYS = 32'h1234_5678;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] vendor = 32'h0300_10EE;
    logic [31:0] ccrev  = 32'h0B40_0000;
    logic        sta = 1'b0;
    logic        io_en, mem_en, bm_en, hit;
    logic [31:0] bar0;
    logic [31:0] addr_in = 32'h0;
    logic        addr_valid = 1'b0;

    always #5 CLK = ~CLK;

    pci_cfg_space_if cfg();

    pci_cfg_space #(
        .BAR0_MASK(MASK), .BAR0_IO(1'b1), .INT_PIN(8'h01), .SUBSYS_ID(SUBSYS)
    ) dut (
        .CLK(CLK), .RST(RST), .CFG_VENDOR(vendor), .CFG_CC_REVISION(ccrev),
        .cfg(cfg), .STAT_STA(sta), .IO_EN(io_en), .MEM_EN(mem_en), .BM_EN(bm_en),
        .BAR0(bar0), .ADDR_IN(addr_in), .ADDR_VALID(addr_valid), .BAR0_HIT(hit)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: stored dword per index plus the status event flag.
    logic [31:0] m_reg [0:63];
    logic        m_sta;

    function automatic logic [31:0] wmask(input logic [5:0] idx);
        case (idx)
            6'h01:   return 32'h0000_0147;
            6'h03:   return 32'h0000_FF00;
            6'h04:   return MASK;
            6'h0F:   return 32'h0000_00FF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [5:0] idx);
        case (idx)
            6'h00: return vendor;
            6'h01: return m_reg[1] | 32'h0200_0000 | (m_sta ? 32'h0800_0000 : 32'h0);
            6'h02: return ccrev;
            6'h03: return m_reg[3];
            6'h04: return m_reg[4] | 32'h1;
            6'h0F: return m_reg[15] | 32'h0000_0100;
`ifdef CFG_SUBSYS_EN
            6'h0B: return SUBSYS;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 32'h0;
        m_sta = 1'b0;
    endtask

    task automatic m_write(input logic [5:0] idx, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & wmask(idx);
        m_reg[idx] = (m_reg[idx] & ~m) | (wd & m);
        if (idx == 6'h01 && be[3] && wd[27]) m_sta = 1'b0;
    endtask

    // One config access; returns the data seen during the ACK cycle.
    task automatic xfer(input logic we, input logic [5:0] idx, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd);
        cfg.CFG_REQ = 1'b1; cfg.CFG_WE = we; cfg.CFG_ADDR = idx;
        cfg.CFG_BE = be; cfg.CFG_WDATA = wd;
        @(posedge CLK); #1;
        chk("ack_high", {31'h0, cfg.CFG_ACK}, 32'h1);
        rd = cfg.CFG_RDATA;
        @(posedge CLK); #1;
        chk("ack_low", {31'h0, cfg.CFG_ACK}, 32'h0);
        chk("rdata_idle", cfg.CFG_RDATA, 32'h0);
        cfg.CFG_REQ = 1'b0; cfg.CFG_WE = 1'b0;
        @(posedge CLK); #1;
        if (we) m_write(idx, be, wd);
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  idx;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        do_chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];
    logic [31:0] rd;
    logic [5:0]  idx_pick [0:7];

    initial begin
        cfg.CFG_REQ = 1'b0; cfg.CFG_WE = 1'b0; cfg.CFG_ADDR = 6'h0;
        cfg.CFG_BE = 4'h0; cfg.CFG_WDATA = 32'h0;
        m_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack", {31'h0, cfg.CFG_ACK}, 32'h0);
        chk("rst_rdata", cfg.CFG_RDATA, 32'h0);
        chk("rst_en", {29'h0, bm_en, mem_en, io_en}, 32'h0);
        chk("rst_bar0", bar0, 32'h0000_0001);
        chk("rst_hit", {31'h0, hit}, 32'h0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Directed vectors
        vt.push_back('{1'b0, 6'h00, 4'hF, 32'h0, 1'b1, 32'h0300_10EE});
        vt.push_back('{1'b0, 6'h02, 4'hF, 32'h0, 1'b1, 32'h0B40_0000});
        vt.push_back('{1'b1, 6'h04, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h04, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFF1});
        vt.push_back('{1'b1, 6'h04, 4'hF, 32'h0000_1230, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h04, 4'hF, 32'h0, 1'b1, 32'h0000_1231});
        vt.push_back('{1'b1, 6'h0F, 4'h1, 32'hFFFF_FF0B, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h0F, 4'hF, 32'h0, 1'b1, 32'h0000_010B});
        vt.push_back('{1'b1, 6'h03, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h03, 4'hF, 32'h0, 1'b1, 32'h0000_0000});
        vt.push_back('{1'b1, 6'h03, 4'hF, 32'hFFFF_ABFF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h03, 4'hF, 32'h0, 1'b1, 32'h0000_AB00});
        vt.push_back('{1'b1, 6'h01, 4'h3, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h01, 4'hF, 32'h0, 1'b1, 32'h0200_0147});
        vt.push_back('{1'b1, 6'h01, 4'hF, 32'h0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h01, 4'hF, 32'h0, 1'b1, 32'h0200_0000});
        vt.push_back('{1'b1, 6'h05, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 6'h05, 4'hF, 32'h0, 1'b1, 32'h0000_0000});
`ifdef CFG_SUBSYS_EN
        vt.push_back('{1'b0, 6'h0B, 4'hF, 32'h0, 1'b1, SUBSYS});
`else
        vt.push_back('{1'b0, 6'h0B, 4'hF, 32'h0, 1'b1, 32'h0});
`endif
        foreach (vt[i]) begin
            xfer(vt[i].we, vt[i].idx, vt[i].be, vt[i].wd, rd);
            if (vt[i].do_chk) chk($sformatf("vec%0d_idx%0h", i, vt[i].idx), rd, vt[i].exp);
        end

        // BAR0 decode, BAR0 = 0x1230
        xfer(1'b1, 6'h01, 4'hF, 32'h1, rd);
        chk("io_en_set", {30'h0, mem_en, io_en}, 32'h1);
        addr_in = 32'h1238; addr_valid = 1'b1;
        @(posedge CLK); #1;
        chk("hit_in_range", {31'h0, hit}, 32'h1);
        addr_in = 32'h1240;
        @(posedge CLK); #1;
        chk("hit_out_range", {31'h0, hit}, 32'h0);
        addr_in = 32'h1238; addr_valid = 1'b0;
        @(posedge CLK); #1;
        chk("hit_not_valid", {31'h0, hit}, 32'h0);
        xfer(1'b1, 6'h01, 4'hF, 32'h0, rd);
        addr_valid = 1'b1;
        @(posedge CLK); #1;
        chk("hit_io_dis", {31'h0, hit}, 32'h0);
        addr_valid = 1'b0;

        // Status bit27 RW1C, set wins over a coincident clear
        sta = 1'b1; @(posedge CLK); #1; sta = 1'b0; m_sta = 1'b1;
        xfer(1'b0, 6'h01, 4'hF, 32'h0, rd);
        chk("sta_set", rd, 32'h0A00_0000);
        sta = 1'b1;
        xfer(1'b1, 6'h01, 4'b1000, 32'h0800_0000, rd);
        sta = 1'b0; m_sta = 1'b1;
        xfer(1'b0, 6'h01, 4'hF, 32'h0, rd);
        chk("sta_set_wins", rd, 32'h0A00_0000);
        xfer(1'b1, 6'h01, 4'b1000, 32'h0800_0000, rd);
        xfer(1'b0, 6'h01, 4'hF, 32'h0, rd);
        chk("sta_cleared", rd, 32'h0200_0000);

        // Reset landing in the ACK cycle of a BAR0 write
        xfer(1'b1, 6'h01, 4'hF, 32'h7, rd);
        chk("en_all", {29'h0, bm_en, mem_en, io_en}, 32'h7);
        cfg.CFG_REQ = 1'b1; cfg.CFG_WE = 1'b1; cfg.CFG_ADDR = 6'h04;
        cfg.CFG_BE = 4'hF; cfg.CFG_WDATA = 32'h0000_5670;
        @(posedge CLK); #1;
        chk("midrst_ack", {31'h0, cfg.CFG_ACK}, 32'h1);
        RST = 1'b1; cfg.CFG_REQ = 1'b0; cfg.CFG_WE = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_ack_low", {31'h0, cfg.CFG_ACK}, 32'h0);
        chk("midrst_en", {29'h0, bm_en, mem_en, io_en}, 32'h0);
        chk("midrst_bar0", bar0, 32'h0000_0001);
        RST = 1'b0; m_reset();
        @(posedge CLK); #1;
        xfer(1'b0, 6'h04, 4'hF, 32'h0, rd);
        chk("postrst_bar0", rd, 32'h0000_0001);
        xfer(1'b0, 6'h00, 4'hF, 32'h0, rd);
        chk("postrst_vendor", rd, 32'h0300_10EE);

        // Random traffic against the model
        idx_pick = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h0F, 6'h0B, 6'h00};
        for (int n = 0; n < 300; n++) begin
            logic        we, pulse, v, exp_hit;
            logic [5:0]  idx;
            logic [3:0]  be;
            logic [31:0] wd, a, exp;
            v     = 1'($urandom_range(0, 3) != 0);
            pulse = 1'($urandom_range(0, 7) == 0);
            a     = ($urandom_range(0, 1) == 1) ? (((m_reg[4] | 32'h1) & MASK) | 32'($urandom_range(0, 15)))
                                                : $urandom;
            exp_hit = v && (((a ^ (m_reg[4] | 32'h1)) & MASK) == 32'h0) && m_reg[1][0];
            chk("rnd_bar0", bar0, m_reg[4] | 32'h1);
            chk("rnd_en", {29'h0, bm_en, mem_en, io_en}, {29'h0, m_reg[1][2:0]});
            addr_in = a; addr_valid = v; sta = pulse;
            @(posedge CLK); #1;
            chk("rnd_hit", {31'h0, hit}, {31'h0, exp_hit});
            addr_valid = 1'b0; sta = 1'b0;
            if (pulse) m_sta = 1'b1;
            we  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(0, 63)) : idx_pick[$urandom_range(0, 6)];
            be  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            exp = exp_rd(idx);
            xfer(we, idx, be, wd, rd);
            if (!we) chk($sformatf("rnd_rd_idx%0h", idx), rd, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
